// File: rtl/qed_pkg.sv
// Shared constants and helpers for the QED register-pair consistency checker.
package qed_pkg;

  localparam int unsigned RF_ADDR_W = 5;
  localparam int unsigned IDX_W     = 4;
  localparam int unsigned STATE_W   = 3;

  localparam logic [RF_ADDR_W-1:0] QED_HALF     = 5'd16;
  localparam logic [IDX_W-1:0]     QED_LAST_IDX = 4'd15;
  localparam logic [IDX_W-1:0]     QED_FIRST_IDX = 4'd1;

  localparam logic [STATE_W-1:0] ST_IDLE  = 3'd0;
  localparam logic [STATE_W-1:0] ST_RD_LO = 3'd1;
  localparam logic [STATE_W-1:0] ST_RD_HI = 3'd2;
  localparam logic [STATE_W-1:0] ST_CMP   = 3'd3;
  localparam logic [STATE_W-1:0] ST_HALT  = 3'd4;

  // Original register r[i] lives in the low half, its duplicate at r[i+16].
  function automatic logic [RF_ADDR_W-1:0] lo_addr(input logic [IDX_W-1:0] idx);
    return RF_ADDR_W'(idx);
  endfunction

  function automatic logic [RF_ADDR_W-1:0] hi_addr(input logic [IDX_W-1:0] idx);
    return QED_HALF | RF_ADDR_W'(idx);
  endfunction

endpackage

// File: rtl/qed_pending_counter.sv
// Outstanding-duplicate bookkeeping: pending count, dirty flag and the
// sticky ordering/overflow errors derived from the commit stream.
module qed_pending_counter
  import qed_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic ena,
  input  logic commit_valid,
  input  logic commit_is_dup,
  input  logic clr_dirty,
  output logic pend_zero,
  output logic dirty,
  output logic order_error,
  output logic ovf_error
);

  logic [CNT_W-1:0] pend_q, pend_d;
  logic             pend_zero_q;
  logic             dirty_q, dirty_d;
  logic             order_q, order_d;
  logic             ovf_q, ovf_d;

  // Saturating up/down count; an illegal step holds the count and raises a flag.
  always_comb begin
    pend_d  = pend_q;
    dirty_d = dirty_q;
    order_d = order_q;
    ovf_d   = ovf_q;
    if (clr_dirty) begin
      dirty_d = 1'b0;
    end
    if (ena && commit_valid) begin
      if (commit_is_dup) begin
        if (pend_q == '0) begin
          order_d = 1'b1;
        end else begin
          pend_d = pend_q - CNT_W'(1);
        end
      end else begin
        dirty_d = 1'b1;
        if (&pend_q) begin
          ovf_d = 1'b1;
        end else begin
          pend_d = pend_q + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q      <= '0;
      pend_zero_q <= 1'b1;
      dirty_q     <= 1'b0;
      order_q     <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      pend_q      <= pend_d;
      pend_zero_q <= (pend_d == '0);
      dirty_q     <= dirty_d;
      order_q     <= order_d;
      ovf_q       <= ovf_d;
    end
  end

  assign pend_zero   = pend_zero_q;
  assign dirty       = dirty_q;
  assign order_error = order_q;
  assign ovf_error   = ovf_q;

endmodule

// File: rtl/qed_consistency_checker.sv
// EDDI-V consumer: once all originals have committed duplicates, compares
// r[i] against r[i+16] for i=1..15 through a synchronous RF read port.
module qed_consistency_checker
  import qed_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ena,
  input  logic                 commit_valid,
  input  logic                 commit_is_dup,
  output logic [RF_ADDR_W-1:0] rf_rd_addr,
  input  logic [XLEN-1:0]      rf_rd_data,
  output logic                 check_busy,
  output logic                 qed_consistent,
  output logic                 qed_error,
  output logic [IDX_W-1:0]     err_reg_idx,
  output logic                 order_error,
  output logic                 ovf_error
);

  logic [STATE_W-1:0]   state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [XLEN-1:0]      lo_q, lo_d;
  logic [RF_ADDR_W-1:0] addr_q, addr_d;
  logic                 busy_q, busy_d;
  logic                 cons_q, cons_d;
  logic                 qerr_q, qerr_d;
  logic [IDX_W-1:0]     eidx_q, eidx_d;
  logic                 clr_dirty;
  logic                 pend_zero;
  logic                 dirty;
  logic                 commit;

  assign commit = ena && commit_valid;

  qed_pending_counter #(
    .CNT_W (CNT_W)
  ) u_pending (
    .clk           (clk),
    .rst           (rst),
    .ena           (ena),
    .commit_valid  (commit_valid),
    .commit_is_dup (commit_is_dup),
    .clr_dirty     (clr_dirty),
    .pend_zero     (pend_zero),
    .dirty         (dirty),
    .order_error   (order_error),
    .ovf_error     (ovf_error)
  );

  // Scan FSM: any commit during a scan aborts it, and beats a same-cycle verdict.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    lo_d      = lo_q;
    cons_d    = 1'b0;
    qerr_d    = qerr_q;
    eidx_d    = eidx_q;
    clr_dirty = 1'b0;
    if (!ena) begin
      if (state_q != ST_HALT) begin
        state_d = ST_IDLE;
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pend_zero && dirty && !commit_valid && !order_error &&
              !ovf_error && !qerr_q) begin
            state_d = ST_RD_LO;
            idx_d   = QED_FIRST_IDX;
          end
        end
        ST_RD_LO: begin
          state_d = commit ? ST_IDLE : ST_RD_HI;
        end
        ST_RD_HI: begin
          lo_d    = rf_rd_data;
          state_d = commit ? ST_IDLE : ST_CMP;
        end
        ST_CMP: begin
          if (commit) begin
            state_d = ST_IDLE;
          end else if (rf_rd_data != lo_q) begin
            qerr_d  = 1'b1;
            eidx_d  = idx_q;
            state_d = ST_HALT;
          end else if (idx_q == QED_LAST_IDX) begin
            cons_d    = 1'b1;
            clr_dirty = 1'b1;
            state_d   = ST_IDLE;
          end else begin
            idx_d   = idx_q + 4'd1;
            state_d = ST_RD_LO;
          end
        end
        ST_HALT: begin
          state_d = ST_HALT;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Read address and busy flag are registered images of the next state.
  always_comb begin
    busy_d = 1'b0;
    addr_d = '0;
    case (state_d)
      ST_RD_LO: begin
        busy_d = 1'b1;
        addr_d = lo_addr(idx_d);
      end
      ST_RD_HI: begin
        busy_d = 1'b1;
        addr_d = hi_addr(idx_d);
      end
      ST_CMP: begin
        busy_d = 1'b1;
      end
      default: begin
        busy_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= QED_FIRST_IDX;
      lo_q    <= '0;
      addr_q  <= '0;
      busy_q  <= 1'b0;
      cons_q  <= 1'b0;
      qerr_q  <= 1'b0;
      eidx_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      lo_q    <= lo_d;
      addr_q  <= addr_d;
      busy_q  <= busy_d;
      cons_q  <= cons_d;
      qerr_q  <= qerr_d;
      eidx_q  <= eidx_d;
    end
  end

  assign rf_rd_addr     = addr_q;
  assign check_busy     = busy_q;
  assign qed_consistent = cons_q;
  assign qed_error      = qerr_q;
  assign err_reg_idx    = eidx_q;

endmodule

// File: tb/tb_qed_consistency_checker.sv
// Bench: two checker instances (CNT_W=16 and CNT_W=2) against a scan-step model.
module tb_qed_consistency_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        ena = 1'b0;
  logic        cv  = 1'b0;
  logic        dup = 1'b0;
  logic [31:0] rf [32];

  logic [4:0]  addr [2];
  logic [31:0] rd   [2];
  logic        busy [2];
  logic        cons [2];
  logic        qerr [2];
  logic [3:0]  eidx [2];
  logic        oe   [2];
  logic        ve   [2];

  qed_consistency_checker #(.XLEN(32), .CNT_W(16)) u0 (
    .clk(clk), .rst(rst), .ena(ena), .commit_valid(cv), .commit_is_dup(dup),
    .rf_rd_addr(addr[0]), .rf_rd_data(rd[0]), .check_busy(busy[0]),
    .qed_consistent(cons[0]), .qed_error(qerr[0]), .err_reg_idx(eidx[0]),
    .order_error(oe[0]), .ovf_error(ve[0]));

  qed_consistency_checker #(.XLEN(32), .CNT_W(2)) u1 (
    .clk(clk), .rst(rst), .ena(ena), .commit_valid(cv), .commit_is_dup(dup),
    .rf_rd_addr(addr[1]), .rf_rd_data(rd[1]), .check_busy(busy[1]),
    .qed_consistent(cons[1]), .qed_error(qerr[1]), .err_reg_idx(eidx[1]),
    .order_error(oe[1]), .ovf_error(ve[1]));

  // Synchronous register file: data for last cycle's address.
  always @(posedge clk) begin
    rd[0] <= rf[addr[0]];
    rd[1] <= rf[addr[1]];
  end

  int tests = 0;
  int fails = 0;

  // Model: a scan is just a step number 0..44 (pair = step/3+1, phase = step%3).
  int m_max  [2] = '{65535, 3};
  int m_pend [2];
  int m_step [2];
  int m_eidx [2];
  bit m_dirty[2];
  bit m_oe   [2];
  bit m_ve   [2];
  bit m_qerr [2];
  bit m_halt [2];
  bit m_cons [2];

  int busy_cnt   = 0;
  int pulse_cnt  = 0;
  int first_addr = -1;

  task automatic check(input string name, input int k, input logic [31:0] act,
                       input logic [31:0] exp_v);
    tests++;
    if (act !== exp_v) begin
      fails++;
      $display("FAIL %s[u%0d] got=%0h want=%0h at %0t", name, k, act, exp_v, $time);
    end
  endtask

  function automatic logic [31:0] exp_addr(input int s);
    if (s < 0) return 32'd0;
    case (s % 3)
      0:       return 32'(s / 3 + 1);
      1:       return 32'(s / 3 + 17);
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      automatic bit commit = ena && cv;
      automatic int p;
      if (rst) begin
        m_pend[k] = 0; m_step[k] = -1; m_eidx[k] = 0; m_dirty[k] = 0;
        m_oe[k] = 0; m_ve[k] = 0; m_qerr[k] = 0; m_halt[k] = 0; m_cons[k] = 0;
      end else begin
        m_cons[k] = 0;
        if (ena && !m_halt[k]) begin
          if (m_step[k] >= 0) begin
            p = m_step[k] / 3 + 1;
            if (commit) m_step[k] = -1;
            else if (m_step[k] % 3 == 2) begin
              if (rf[p] != rf[p+16]) begin
                m_qerr[k] = 1; m_eidx[k] = p; m_halt[k] = 1; m_step[k] = -1;
              end else if (p == 15) begin
                m_cons[k] = 1; m_dirty[k] = 0; m_step[k] = -1;
              end else m_step[k]++;
            end else m_step[k]++;
          end else if (m_pend[k] == 0 && m_dirty[k] && !cv && !m_oe[k] &&
                       !m_ve[k] && !m_qerr[k]) begin
            m_step[k] = 0;
          end
        end else begin
          m_step[k] = -1;
        end
        if (commit) begin
          if (dup) begin
            if (m_pend[k] == 0) m_oe[k] = 1;
            else m_pend[k]--;
          end else begin
            m_dirty[k] = 1;
            if (m_pend[k] == m_max[k]) m_ve[k] = 1;
            else m_pend[k]++;
          end
        end
      end
    end
  endtask

  task automatic compare_all();
    for (int k = 0; k < 2; k++) begin
      check("check_busy", k, 32'(busy[k]), 32'(m_step[k] >= 0));
      check("rf_rd_addr", k, 32'(addr[k]), exp_addr(m_step[k]));
      check("qed_consistent", k, 32'(cons[k]), 32'(m_cons[k]));
      check("qed_error", k, 32'(qerr[k]), 32'(m_qerr[k]));
      check("err_reg_idx", k, 32'(eidx[k]), 32'(m_eidx[k]));
      check("order_error", k, 32'(oe[k]), 32'(m_oe[k]));
      check("ovf_error", k, 32'(ve[k]), 32'(m_ve[k]));
    end
    if (busy[0] === 1'b1) begin
      if (busy_cnt == 0) first_addr = int'(addr[0]);
      busy_cnt++;
    end
    if (cons[0] === 1'b1) pulse_cnt++;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic idle(input int n);
    cv = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic commit(input logic is_dup);
    cv = 1'b1;
    dup = is_dup;
    tick();
    cv = 1'b0;
    dup = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; ena = 1'b0; cv = 1'b0; dup = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    ena = 1'b1;
  endtask

  task automatic clear_stats();
    busy_cnt = 0; pulse_cnt = 0; first_addr = -1;
  endtask

  task automatic clean_rf();
    for (int i = 0; i < 16; i++) begin
      rf[i]    = 32'h11 * 32'(i);
      rf[i+16] = 32'h11 * 32'(i);
    end
    rf[16] = 32'hFFFF_0000;
  endtask

  initial begin
    bit found;
    clean_rf();

    // Reset state
    do_reset();
    check("rst_busy", 0, 32'(busy[0]), 32'd0);
    check("rst_addr", 0, 32'(addr[0]), 32'd0);
    check("rst_err", 0, 32'(qerr[0]), 32'd0);

    // Balanced commits -> one full clean scan
    repeat (3) commit(1'b0);
    repeat (3) commit(1'b1);
    clear_stats();
    idle(60);
    check("t2_busy_cycles", 0, 32'(busy_cnt), 32'd45);
    check("t2_pulses", 0, 32'(pulse_cnt), 32'd1);
    check("t2_first_addr", 0, 32'(first_addr), 32'd1);
    check("t2_qed_error", 0, 32'(qerr[0]), 32'd0);

    // Mismatch at pair 5
    rf[5] = 32'hDEAD; rf[21] = 32'hBEEF;
    commit(1'b0);
    commit(1'b1);
    clear_stats();
    idle(100);
    check("t3_qed_error", 0, 32'(qerr[0]), 32'd1);
    check("t3_err_idx", 0, 32'(eidx[0]), 32'd5);
    check("t3_busy_cycles", 0, 32'(busy_cnt), 32'd15);
    check("t3_pulses", 0, 32'(pulse_cnt), 32'd0);

    // Abort at pair 7, then rescan from idx 1
    clean_rf();
    do_reset();
    commit(1'b0);
    commit(1'b1);
    found = 1'b0;
    for (int i = 0; i < 80 && !found; i++) begin
      tick();
      if (addr[0] == 5'd7) found = 1'b1;
    end
    check("t4_reach_pair7", 0, 32'(found), 32'd1);
    commit(1'b0);
    check("t4_abort_busy", 0, 32'(busy[0]), 32'd0);
    clear_stats();
    idle(50);
    check("t4_no_pulse", 0, 32'(pulse_cnt), 32'd0);
    check("t4_no_scan", 0, 32'(busy_cnt), 32'd0);
    commit(1'b1);
    clear_stats();
    idle(60);
    check("t4_rescan_cycles", 0, 32'(busy_cnt), 32'd45);
    check("t4_rescan_first", 0, 32'(first_addr), 32'd1);
    check("t4_rescan_pulse", 0, 32'(pulse_cnt), 32'd1);

    // Duplicate before any original
    do_reset();
    commit(1'b1);
    check("t5_order_error", 0, 32'(oe[0]), 32'd1);
    commit(1'b0);
    commit(1'b1);
    clear_stats();
    idle(60);
    check("t5_no_scan", 0, 32'(busy_cnt), 32'd0);

    // Overflow on the 2-bit counter instance, pend held at 3
    do_reset();
    repeat (3) commit(1'b0);
    check("t6_ovf_before", 1, 32'(ve[1]), 32'd0);
    commit(1'b0);
    check("t6_ovf_after", 1, 32'(ve[1]), 32'd1);
    check("t6_ovf_wide", 0, 32'(ve[0]), 32'd0);
    repeat (3) commit(1'b1);
    check("t6_pend_held3", 1, 32'(oe[1]), 32'd0);
    commit(1'b1);
    check("t6_order_after4", 1, 32'(oe[1]), 32'd1);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      tick();
      if (busy[0] === 1'b1) found = 1'b1;
    end
    check("t6_scan_started", 0, 32'(found), 32'd1);
    idle(10);
    ena = 1'b0;
    tick();
    check("t6_ena_off_busy", 0, 32'(busy[0]), 32'd0);
    idle(5);
    ena = 1'b1;
    idle(60);

    // Randomised bursts of commits followed by quiet windows
    for (int seg = 0; seg < 4; seg++) begin
      for (int i = 0; i < 32; i++) rf[i] = $urandom;
      for (int i = 1; i < 16; i++) rf[i+16] = rf[i];
      if (seg % 2 == 1) rf[$urandom_range(17, 31)] = ~rf[0];
      do_reset();
      for (int b = 0; b < 6; b++) begin
        for (int c = 0; c < 12; c++) begin
          ena = ($urandom_range(0, 31) != 0);
          cv  = ($urandom_range(0, 2) == 0);
          dup = (m_pend[0] > 0) ? ($urandom_range(0, 2) != 0)
                                : ($urandom_range(0, 15) == 0);
          tick();
        end
        cv = 1'b0;
        ena = 1'b1;
        for (int c = 0; c < 20 && m_pend[0] > 0; c++) commit(1'b1);
        for (int c = 0; c < 55; c++) begin
          ena = ($urandom_range(0, 63) != 0);
          tick();
        end
        ena = 1'b1;
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
